// File: rtl/rpn_sequencer.sv
// rpn_sequencer: turns a stream of RPN tokens into push/op/step controls for
// the stack calculator. It tracks a shadow stack depth so that tokens which
// would overflow or underflow are rejected before they reach the calculator.
// After each step it compares that depth with the calculator's count, and it
// returns the final expression value over a valid/ready handshake.
module rpn_sequencer #(
  parameter int DEPTH = 1000,
  parameter int W     = 16,
  parameter int CW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tok_valid,
  output logic          tok_ready,
  input  logic          tok_is_op,
  input  logic [W-1:0]  tok_data,
  input  logic [1:0]    tok_op,
  output logic          calc_step,
  output logic          calc_push,
  output logic [W-1:0]  calc_d,
  output logic [1:0]    calc_op,
  output logic          calc_clear,
  input  logic [W-1:0]  calc_out,
  input  logic [CW-1:0] calc_cnt,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  result,
  output logic          err,
  output logic [2:0]    err_code,
  input  logic          flush
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;

  localparam logic [1:0] OP_END = 2'd0;
  localparam logic [1:0] OP_NEG = 2'd1;

  localparam logic [2:0] E_NONE     = 3'd0;
  localparam logic [2:0] E_OVERFLOW = 3'd1;
  localparam logic [2:0] E_UNDERFLW = 3'd2;
  localparam logic [2:0] E_UNBAL    = 3'd3;
  localparam logic [2:0] E_DESYNC   = 3'd4;

  localparam logic [CW-1:0] DEPTH_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] TWO       = CW'(2);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] depth_q, depth_d;
  logic          push_q, push_d;
  logic [W-1:0]  d_q, d_d;
  logic [1:0]    op_q, op_d;
  logic [W-1:0]  result_q, result_d;
  logic [2:0]    err_code_q, err_code_d;
  logic          clear_q, clear_d;

  logic tok_fire;
  logic latch_active;

  assign tok_fire     = tok_valid && (state_q == S_IDLE);
  assign latch_active = (state_q == S_ISSUE) || (state_q == S_SETTLE);

  // Next-state, depth bookkeeping, token latching and error capture.
  always_comb begin
    // NOTE: every variable gets a default here, so no path can infer a latch.
    state_d    = state_q;
    depth_d    = depth_q;
    push_d     = push_q;
    d_d        = d_q;
    op_d       = op_q;
    result_d   = result_q;
    err_code_d = err_code_q;
    clear_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tok_fire) begin
          if (!tok_is_op) begin
            if (depth_q == DEPTH_MAX) begin
              state_d    = S_ERR;
              err_code_d = E_OVERFLOW;
            end else begin
              push_d  = 1'b1;
              d_d     = tok_data;
              state_d = S_ISSUE;
            end
          end else if (tok_op == OP_END) begin
            if (depth_q == ONE) begin
              result_d = calc_out;
              state_d  = S_DONE;
            end else begin
              state_d    = S_ERR;
              err_code_d = E_UNBAL;
            end
          end else if ((tok_op == OP_NEG && depth_q < ONE) ||
                       (tok_op != OP_NEG && depth_q < TWO)) begin
            state_d    = S_ERR;
            err_code_d = E_UNDERFLW;
          end else begin
            push_d  = 1'b0;
            op_d    = tok_op;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // The checks made at acceptance guarantee that neither update wraps.
        if (push_q)               depth_d = depth_q + ONE;
        else if (op_q != OP_NEG)  depth_d = depth_q - ONE;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (calc_cnt != depth_q) begin
          state_d    = S_ERR;
          err_code_d = E_DESYNC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
          depth_d = '0;
          clear_d = 1'b1;
        end
      end
      S_ERR: begin
        if (flush) begin
          state_d    = S_IDLE;
          depth_d    = '0;
          clear_d    = 1'b1;
          err_code_d = E_NONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; an asynchronous reset returns everything to IDLE at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      depth_q    <= '0;
      push_q     <= 1'b0;
      d_q        <= '0;
      op_q       <= '0;
      result_q   <= '0;
      err_code_q <= E_NONE;
      clear_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
      state_q    <= state_d;
      depth_q    <= depth_d;
      push_q     <= push_d;
      d_q        <= d_d;
      op_q       <= op_d;
      result_q   <= result_d;
      err_code_q <= err_code_d;
      clear_q    <= clear_d;
    end
  end

  // Output decode: the latched controls are visible only during ISSUE/SETTLE.
  always_comb begin
    tok_ready  = (state_q == S_IDLE);
    calc_step  = (state_q == S_ISSUE);
    calc_push  = latch_active && push_q;
    calc_d     = latch_active ? d_q  : '0;
    calc_op    = latch_active ? op_q : '0;
    calc_clear = clear_q;
    res_valid  = (state_q == S_DONE);
    result     = result_q;
    err        = (state_q == S_ERR);
    err_code   = err_code_q;
  end

endmodule

// File: tb/tb_rpn_sequencer.sv
// Directed self-checking bench for rpn_sequencer with a behavioural
// calculator model. The DUT is built with DEPTH=4 so overflow is reachable.
module tb_rpn_sequencer;

  localparam int W  = 16;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          tok_valid, tok_ready, tok_is_op;
  logic [W-1:0]  tok_data;
  logic [1:0]    tok_op;
  logic          calc_step, calc_push, calc_clear;
  logic [W-1:0]  calc_d, calc_out;
  logic [1:0]    calc_op;
  logic [CW-1:0] calc_cnt;
  logic          res_valid, res_ready;
  logic [W-1:0]  result;
  logic          err;
  logic [2:0]    err_code;
  logic          flush;

  int errors = 0;
  int checks = 0;

  rpn_sequencer #(.DEPTH(4), .W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op),
    .tok_data(tok_data), .tok_op(tok_op),
    .calc_step(calc_step), .calc_push(calc_push), .calc_d(calc_d),
    .calc_op(calc_op), .calc_clear(calc_clear),
    .calc_out(calc_out), .calc_cnt(calc_cnt),
    .res_valid(res_valid), .res_ready(res_ready), .result(result),
    .err(err), .err_code(err_code), .flush(flush)
  );

  always #5 clk = ~clk;

  // Behavioural calculator: 8-entry stack, arithmetic mod 2**W.
  logic [W-1:0] stk [0:7];
  int           m_cnt;
  int           step_count;
  int           cnt_log [0:15];
  logic         force_desync;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt      <= 0;
      step_count <= 0;
    end else if (calc_clear) begin
      m_cnt <= 0;
    end else if (calc_step) begin
      step_count <= step_count + 1;
      if (calc_push) begin
        stk[m_cnt & 7]          <= calc_d;
        m_cnt                   <= m_cnt + 1;
        cnt_log[step_count & 15] <= m_cnt + 1;
      end else if (calc_op == 2'd1) begin
        stk[(m_cnt - 1) & 7]    <= W'(0) - stk[(m_cnt - 1) & 7];
        cnt_log[step_count & 15] <= m_cnt;
      end else begin
        if (calc_op == 2'd2)
          stk[(m_cnt - 2) & 7] <= stk[(m_cnt - 2) & 7] + stk[(m_cnt - 1) & 7];
        else
          stk[(m_cnt - 2) & 7] <= stk[(m_cnt - 2) & 7] * stk[(m_cnt - 1) & 7];
        m_cnt                   <= m_cnt - 1;
        cnt_log[step_count & 15] <= m_cnt - 1;
      end
    end
  end

  always_comb begin
    calc_out = '0;
    if (m_cnt > 0) calc_out = stk[(m_cnt - 1) & 7];
    calc_cnt = force_desync ? '0 : CW'(m_cnt);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!tok_ready && n < 50) begin
      tick();
      n++;
    end
    if (!tok_ready) check("tok_ready_timeout", 32'(tok_ready), 32'd1);
  endtask

  // Presents one token and returns 1 time unit after the accepting edge.
  task automatic send(input logic is_op, input logic [1:0] op, input logic [W-1:0] data);
    wait_ready();
    tok_is_op = is_op;
    tok_op    = op;
    tok_data  = data;
    tok_valid = 1'b1;
    tick();
    tok_valid = 1'b0;
  endtask

  task automatic push_val(input logic [W-1:0] v);
    send(1'b0, 2'd0, v);
  endtask

  task automatic op_tok(input logic [1:0] op);
    send(1'b1, op, '0);
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  int s0;

  initial begin
    rst = 1'b1; tok_valid = 0; tok_is_op = 0; tok_data = '0; tok_op = '0;
    res_ready = 0; flush = 0; force_desync = 0;
    #1;
    check("rst_tok_ready", 32'(tok_ready), 32'd1);
    check("rst_calc_step", 32'(calc_step), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // 3 4 + 5 * end -> 35
    push_val(16'd3);
    check("issue_step", 32'(calc_step), 32'd1);
    check("issue_push", 32'(calc_push), 32'd1);
    check("issue_d", 32'(calc_d), 32'd3);
    check("issue_tok_ready", 32'(tok_ready), 32'd0);
    tick();
    check("settle_step", 32'(calc_step), 32'd0);
    check("settle_d", 32'(calc_d), 32'd3);
    push_val(16'd4);
    op_tok(2'd2);
    check("issue_op", 32'(calc_op), 32'd2);
    push_val(16'd5);
    op_tok(2'd3);
    op_tok(2'd0);
    check("expr1_steps", 32'(step_count), 32'd5);
    check("expr1_cnt0", 32'(cnt_log[0]), 32'd1);
    check("expr1_cnt1", 32'(cnt_log[1]), 32'd2);
    check("expr1_cnt2", 32'(cnt_log[2]), 32'd1);
    check("expr1_cnt3", 32'(cnt_log[3]), 32'd2);
    check("expr1_cnt4", 32'(cnt_log[4]), 32'd1);
    check("expr1_valid", 32'(res_valid), 32'd1);
    check("expr1_result", 32'(result), 32'h0023);
    check("expr1_calc_d_idle", 32'(calc_d), 32'd0);
    take_result();
    check("expr1_valid_drop", 32'(res_valid), 32'd0);
    check("expr1_clear", 32'(calc_clear), 32'd1);
    tick();
    check("expr1_clear_once", 32'(calc_clear), 32'd0);

    // 7 neg end -> 0xFFF9, with a stalled consumer
    push_val(16'd7);
    op_tok(2'd1);
    op_tok(2'd0);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(res_valid), 32'd1);
      check("stall_result", 32'(result), 32'hFFF9);
      check("stall_tok_ready", 32'(tok_ready), 32'd0);
      tick();
    end
    take_result();
    check("expr2_clear", 32'(calc_clear), 32'd1);

    // 9 + -> underflow
    s0 = step_count;
    push_val(16'd9);
    op_tok(2'd2);
    check("uf_err", 32'(err), 32'd1);
    check("uf_code", 32'(err_code), 32'd2);
    repeat (3) tick();
    check("uf_steps", 32'(step_count - s0), 32'd1);
    check("uf_tok_ready", 32'(tok_ready), 32'd0);
    check("uf_code_held", 32'(err_code), 32'd2);
    do_flush();
    check("uf_flush_clear", 32'(calc_clear), 32'd1);
    check("uf_flush_err", 32'(err), 32'd0);
    check("uf_flush_code", 32'(err_code), 32'd0);
    push_val(16'd2);
    op_tok(2'd0);
    check("uf_next_result", 32'(result), 32'd2);
    take_result();

    // five pushes with DEPTH=4 -> overflow on the fifth
    s0 = step_count;
    for (int i = 1; i <= 5; i++) push_val(16'(i));
    check("of_steps", 32'(step_count - s0), 32'd4);
    check("of_err", 32'(err), 32'd1);
    check("of_code", 32'(err_code), 32'd1);
    do_flush();

    // 1 2 end -> unbalanced end
    push_val(16'd1);
    push_val(16'd2);
    op_tok(2'd0);
    check("unbal_code", 32'(err_code), 32'd3);
    do_flush();

    // end on empty stack -> unbalanced end
    op_tok(2'd0);
    check("empty_end_code", 32'(err_code), 32'd3);
    do_flush();

    // calculator count disagreeing after a push -> desync
    force_desync = 1'b1;
    push_val(16'd5);
    tick();
    tick();
    check("desync_err", 32'(err), 32'd1);
    check("desync_code", 32'(err_code), 32'd4);
    do_flush();
    force_desync = 1'b0;

    // async reset while calc_step is high
    wait_ready();
    tok_is_op = 1'b0; tok_data = 16'd6; tok_valid = 1'b1;
    tick();
    tok_valid = 1'b0;
    check("mid_issue_step", 32'(calc_step), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_step", 32'(calc_step), 32'd0);
    check("arst_push", 32'(calc_push), 32'd0);
    check("arst_d", 32'(calc_d), 32'd0);
    check("arst_tok_ready", 32'(tok_ready), 32'd1);
    check("arst_result", 32'(result), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    push_val(16'd6);
    op_tok(2'd0);
    check("post_rst_valid", 32'(res_valid), 32'd1);
    check("post_rst_result", 32'(result), 32'd6);
    take_result();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
